serial_word_receiver: RTL

//  Downstream stage of the 4-bit load/shift register: consumes its SO stream, one bit per shift strobe.

---
 rtl/serial_rx_pkg.sv | 16 +
 rtl/rx_hold_reg.sv | 39 +++
 rtl/serial_word_receiver.sv | 109 ++++++++++
 3 files changed

// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial word receiver: FSM encoding, default width, parity helper.
package serial_rx_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PARITY  = 1'b1
    } rx_state_t;

    localparam int RX_WIDTH_DEF = 4;

    // Even-parity bit over a zero-extended word (1 when the word has an odd number of ones).
    function automatic logic par_even(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// One-entry valid/ready hold buffer; a load is taken when empty or popped on the same edge.
module rx_hold_reg #(
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic          o_full,
    output logic          o_pop
);

    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          w_pop;

    assign w_pop = r_valid & i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load && (!r_valid || w_pop)) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_full  = r_valid;
    assign o_pop   = w_pop;

endmodule

// File: rtl/serial_word_receiver.sv
// Reassembles MSB-first serial frames into WIDTH-bit words behind a one-entry hold buffer.
// Optional even-parity bit per frame is enabled by defining RX_PARITY_EN.
module serial_word_receiver
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = RX_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             si,
    input  logic             clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

    rx_state_t        r_state;
    logic [WIDTH-1:0] r_shift_reg;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_overrun;

    logic [WIDTH-1:0] w_next_word;
    logic             w_load;
    logic [WIDTH-1:0] w_load_data;
    logic             w_load_perr;
    logic [WIDTH:0]   w_hold_data;
    logic             w_full;
    logic             w_pop;

    assign w_next_word = {r_shift_reg[WIDTH-2:0], si};

`ifdef RX_PARITY_EN
    // The parity bit is not shifted in; the data word is already complete in r_shift_reg.
    assign w_load      = shift & ~clr & (r_state == ST_PARITY);
    assign w_load_data = r_shift_reg;
    assign w_load_perr = par_even(32'(r_shift_reg)) ^ si;
`else
    assign w_load      = shift & ~clr & (r_state == ST_COLLECT) & (r_bit_cnt == LAST_DATA);
    assign w_load_data = w_next_word;
    assign w_load_perr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_COLLECT;
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
        end else if (clr) begin
            r_state     <= ST_COLLECT;
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
        end else if (shift) begin
            case (r_state)
                ST_COLLECT: begin
                    r_shift_reg <= w_next_word;
                    if (r_bit_cnt == LAST_DATA) begin
`ifdef RX_PARITY_EN
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_state   <= ST_PARITY;
`else
                        r_bit_cnt <= '0;
`endif
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_bit_cnt <= '0;
                    r_state   <= ST_COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_load && w_full && !w_pop) begin
            r_overrun <= 1'b1;
        end
    end

    rx_hold_reg #(
        .DW(WIDTH + 1)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_data ({w_load_perr, w_load_data}),
        .i_ready(out_ready),
        .o_data (w_hold_data),
        .o_valid(out_valid),
        .o_full (w_full),
        .o_pop  (w_pop)
    );

    assign out_data   = w_hold_data[WIDTH-1:0];
    assign parity_err = w_hold_data[WIDTH];
    assign overrun    = r_overrun;
    assign busy       = (r_bit_cnt != '0);

endmodule
